// File: rtl/superalu_issuer.sv
// superalu_issuer: program store and in-order issuer for the super-ALU datapath.
// Words are appended through the load port, then issued over valid/ready on start.
// Operands naming a register above r7 are trapped instead of issued.
// Optional read-after-write interlock (STALL state, gap counter, last-dest register)
// is built only when SUPERALU_ISSUER_HAZARD_EN is defined.
module superalu_issuer #(
   parameter int DEPTH      = 8,
   parameter int HAZARD_GAP = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   input  logic [47:0]              load_data,
   output logic                     load_ready,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     clear,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [47:0]              inst,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
       HAZARD_GAP < 0 || HAZARD_GAP > 15) begin : g_param_check
      $error("superalu_issuer: DEPTH or HAZARD_GAP out of range");
   end

`ifdef SUPERALU_ISSUER_HAZARD_EN
   typedef enum logic [2:0] {IDLE, RUN, STALL, DONE, ERROR} state_t;
   localparam logic [3:0] GAP = 4'(HAZARD_GAP);
`else
   typedef enum logic [2:0] {IDLE, RUN, DONE, ERROR} state_t;
`endif

   state_t          state, state_nxt;
   logic [47:0]     mem [DEPTH];
   logic [PW-1:0]   pc_nxt;
   logic [CW-1:0]   count_nxt;
   logic [47:0]     inst_nxt;
   logic            valid_nxt, done_nxt, err_nxt;
   logic            load_fire, hs, mem_we;
   logic            present;
   logic [PW-1:0]   slot;
   logic [47:0]     slot_word;
`ifdef SUPERALU_ISSUER_HAZARD_EN
   logic [2:0]      last_dest, last_dest_nxt;
   logic            last_vld, last_vld_nxt;
   logic [3:0]      gap_cnt, gap_nxt;
`endif

   // A register operand is malformed when its number does not fit in 3 bits.
   function automatic logic bad_operand(input logic [47:0] w);
      return (w[38] && (|w[37:33])) || (w[29] && (|w[28:24])) ||
             (w[20] && (|w[19:15])) || (w[11] && (|w[10:6]));
   endfunction

`ifdef SUPERALU_ISSUER_HAZARD_EN
   // True when any register operand of w reads register r.
   function automatic logic reads_reg(input logic [47:0] w, input logic [2:0] r);
      return (w[38] && w[32:30] == r) || (w[29] && w[23:21] == r) ||
             (w[20] && w[14:12] == r) || (w[11] && w[5:3] == r);
   endfunction
`endif

   assign load_ready = (state == IDLE) && (count < FULL);
   assign load_fire  = load_valid && load_ready;
   assign mem_we     = load_fire && !clear;
   assign hs         = inst_valid && inst_ready;
`ifdef SUPERALU_ISSUER_HAZARD_EN
   assign busy = (state == RUN) || (state == STALL);
`else
   assign busy = (state == RUN);
`endif

   // Next-state decode. Any transition that lands on a new slot goes through the
   // 'present' step, so the word is vetted on the same edge it would be offered.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      count_nxt = count;
      inst_nxt  = inst;
      valid_nxt = inst_valid;
      done_nxt  = done;
      err_nxt   = err;
      present   = 1'b0;
      slot      = pc;
`ifdef SUPERALU_ISSUER_HAZARD_EN
      last_dest_nxt = last_dest;
      last_vld_nxt  = last_vld;
      gap_nxt       = (gap_cnt != 4'd0) ? gap_cnt - 4'd1 : 4'd0;
`endif
      if (clear) begin
         state_nxt = IDLE;
         count_nxt = '0;
         pc_nxt    = '0;
         done_nxt  = 1'b0;
         err_nxt   = 1'b0;
         valid_nxt = 1'b0;
      end else if (abort && busy) begin
         state_nxt = IDLE;
         pc_nxt    = '0;
         valid_nxt = 1'b0;
      end else if (load_fire) begin
         count_nxt = count + 1'b1;
      end else if (start && (count != '0) &&
                   (state == IDLE || state == DONE || state == ERROR)) begin
         done_nxt = 1'b0;
         err_nxt  = 1'b0;
         present  = 1'b1;
         slot     = '0;
`ifdef SUPERALU_ISSUER_HAZARD_EN
         last_vld_nxt = 1'b0;
`endif
      end else if (hs) begin
         valid_nxt = 1'b0;
`ifdef SUPERALU_ISSUER_HAZARD_EN
         last_dest_nxt = inst[2:0];
         last_vld_nxt  = 1'b1;
         gap_nxt       = GAP;
`endif
         if ({1'b0, pc} == count - 1'b1) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
         end else begin
            present = 1'b1;
            slot    = pc + 1'b1;
         end
`ifdef SUPERALU_ISSUER_HAZARD_EN
      end else if (state == STALL && gap_nxt == 4'd0) begin
         present = 1'b1;
`endif
      end

      slot_word = mem[slot];
      if (present) begin
         pc_nxt    = slot;
         valid_nxt = 1'b0;
         if (bad_operand(slot_word)) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
         end
`ifdef SUPERALU_ISSUER_HAZARD_EN
         else if (last_vld_nxt && gap_nxt != 4'd0 && reads_reg(slot_word, last_dest_nxt)) begin
            state_nxt = STALL;
         end
`endif
         else begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
            inst_nxt  = slot_word;
         end
      end
   end

   // State and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         count      <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef SUPERALU_ISSUER_HAZARD_EN
         last_dest  <= '0;
         last_vld   <= 1'b0;
         gap_cnt    <= '0;
`endif
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         count      <= count_nxt;
         inst       <= inst_nxt;
         inst_valid <= valid_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
`ifdef SUPERALU_ISSUER_HAZARD_EN
         last_dest  <= last_dest_nxt;
         last_vld   <= last_vld_nxt;
         gap_cnt    <= gap_nxt;
`endif
      end
   end

   // Program store: append at slot 'count'; contents are data and are not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[count[PW-1:0]] <= load_data;
   end

endmodule

// File: tb/tb_superalu_issuer.sv
// tb_superalu_issuer: scoreboard bench for superalu_issuer.
// Stimulus pushes the expected issue stream (word plus expected bubble count)
// computed from the loaded program; an independent monitor pops on each handshake.
`timescale 1ns/1ps
module tb_superalu_issuer;
   localparam int DEPTH      = 8;
   localparam int HAZARD_GAP = 2;
   localparam int PW         = $clog2(DEPTH);
`ifdef SUPERALU_ISSUER_HAZARD_EN
   localparam int EXP_GAP = HAZARD_GAP;
`else
   localparam int EXP_GAP = 0;
`endif
   localparam logic [47:0] W0  = 48'h0A0300C02020;
   localparam logic [47:0] W1  = 48'h0D028100301A;
   localparam logic [47:0] HZ  = 48'h0A4000000001;
   localparam logic [47:0] BAD = 48'h000022000000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic [47:0]   load_data = '0;
   logic          load_ready;
   logic          start = 1'b0, abort = 1'b0, clear = 1'b0;
   logic          inst_valid;
   logic          inst_ready = 1'b0;
   logic [47:0]   inst;
   logic          busy, done, err;
   logic [PW-1:0] pc;
   logic [PW:0]   count;

   typedef struct { logic [47:0] word; int bub; } exp_t;
   exp_t        sb_q[$];
   logic [47:0] prog[$];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          rdy_random = 1'b0;

   superalu_issuer #(.DEPTH(DEPTH), .HAZARD_GAP(HAZARD_GAP)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .start(start), .abort(abort), .clear(clear),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .busy(busy), .done(done), .err(err), .pc(pc), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference model: operand n is the 9-bit {rNs, numN} field based at bit 30-9n.
   function automatic logic [8:0] operand(input logic [47:0] w, input int n);
      logic [47:0] s;
      s = w >> (30 - 9 * n);
      return s[8:0];
   endfunction

   function automatic bit is_bad(input logic [47:0] w);
      logic [8:0] f;
      for (int n = 0; n < 4; n++) begin
         f = operand(w, n);
         if (f[8] && f[7:0] >= 8'd8) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit reads(input logic [47:0] w, input logic [2:0] r);
      logic [8:0] f;
      for (int n = 0; n < 4; n++) begin
         f = operand(w, n);
         if (f[8] && f[7:0] == {5'd0, r}) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [47:0] rand_word();
      logic [47:0] w;
      logic [8:0]  f;
      w = '0;
      w[47:39] = 9'($urandom);
      w[2:0]   = 3'($urandom_range(0, 3));
      for (int n = 0; n < 4; n++) begin
         f[8]   = 1'($urandom_range(0, 1));
         f[7:0] = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) f[7:0] = 8'($urandom_range(8, 255));
         w[38 - 9 * n -: 9] = f;
      end
      return w;
   endfunction

   // Expected issue stream for the current program; returns the trapped slot or -1.
   task automatic push_program(output int err_slot);
      exp_t e;
      err_slot = -1;
      for (int i = 0; i < prog.size(); i++) begin
         if (is_bad(prog[i])) begin
            err_slot = i;
            break;
         end
         e.word = prog[i];
         if (i == 0) e.bub = -1;
         else if (reads(prog[i], prog[i-1][2:0])) e.bub = EXP_GAP;
         else e.bub = 0;
         sb_q.push_back(e);
      end
   endtask

   task automatic load_word(input logic [47:0] w);
      logic exp_rdy;
      exp_rdy = (prog.size() < DEPTH);
      load_valid = 1'b1;
      load_data  = w;
      check("load_ready", 64'(load_ready), 64'(exp_rdy));
      @(posedge clk); #1;
      load_valid = 1'b0;
      if (exp_rdy) prog.push_back(w);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      prog.delete();
      sb_q.delete();
      check("clear count", 64'(count), 64'(0));
      check("clear load_ready", 64'(load_ready), 64'(1));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!(done || err) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!(done || err)) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: done=%0b err=%0b, required done or err", tag, done, err);
      end
   endtask

   task automatic run_program(input bit rnd, input string tag);
      int es;
      push_program(es);
      rdy_random = rnd;
      if (!rnd) inst_ready = 1'b1;
      pulse_start();
      check({tag, " first valid"}, 64'(inst_valid), 64'(es != 0));
      check({tag, " done after start"}, 64'(done), 64'(0));
      check({tag, " err after start"}, 64'(err), 64'(es == 0));
      wait_end(tag);
      rdy_random = 1'b0;
      check({tag, " done"}, 64'(done), 64'(es < 0));
      check({tag, " err"}, 64'(err), 64'(es >= 0));
      check({tag, " pc"}, 64'(pc), 64'((es < 0) ? prog.size() - 1 : es));
      check({tag, " busy"}, 64'(busy), 64'(0));
      check({tag, " valid at end"}, 64'(inst_valid), 64'(0));
      check({tag, " words left"}, 64'(sb_q.size()), 64'(0));
      sb_q.delete();
      @(posedge clk); #1;
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_random) inst_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops the scoreboard on every handshake, checks held words stay put.
   logic [47:0] held_inst;
   bit          held = 1'b0;
   int          bubbles = 0;
   exp_t        mon_e;
   always @(negedge clk) begin
      if (rst) begin
         held    = 1'b0;
         bubbles = 0;
      end else begin
         if (held) begin
            check("hold valid", 64'(inst_valid), 64'(1));
            check("hold inst", 64'(inst), 64'(held_inst));
         end
         held      = inst_valid && !inst_ready && !abort && !clear;
         held_inst = inst;
         if (inst_valid && inst_ready && !abort && !clear) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL issue: got word %h, required no issue", inst);
            end else begin
               mon_e = sb_q.pop_front();
               check("issue word", 64'(inst), 64'(mon_e.word));
               if (mon_e.bub >= 0) check("bubble", 64'(bubbles), 64'(mon_e.bub));
            end
            bubbles = 0;
         end else if (!inst_valid) begin
            bubbles++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int es;
      int n;
      #12;
      check("rst count", 64'(count), 64'(0));
      check("rst pc", 64'(pc), 64'(0));
      check("rst inst", 64'(inst), 64'(0));
      check("rst valid", 64'(inst_valid), 64'(0));
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst err", 64'(err), 64'(0));
      check("rst load_ready", 64'(load_ready), 64'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic two-word program, then abort outside a run is ignored.
      load_word(W0);
      load_word(W1);
      check("basic count", 64'(count), 64'(prog.size()));
      run_program(1'b0, "basic");
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort in done keeps done", 64'(done), 64'(1));
      check("abort in done keeps pc", 64'(pc), 64'(1));

      // Read-after-write interlock.
      do_clear();
      load_word(W0);
      load_word(HZ);
      run_program(1'b0, "hazard");

      // Last-dest is forgotten on start: restart a program whose first word reads the last dest.
      do_clear();
      load_word(HZ);
      load_word(W0);
      run_program(1'b0, "inval");
      run_program(1'b0, "inval restart");

      // Backpressure: word held with pc unchanged.
      do_clear();
      load_word(W0);
      load_word(W1);
      inst_ready = 1'b0;
      push_program(es);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         check("bp valid", 64'(inst_valid), 64'(1));
         check("bp inst", 64'(inst), 64'(W0));
         check("bp pc", 64'(pc), 64'(0));
         @(posedge clk); #1;
      end
      inst_ready = 1'b1;
      wait_end("bp");
      check("bp done", 64'(done), 64'(1));
      check("bp words left", 64'(sb_q.size()), 64'(0));
      @(posedge clk); #1;

      // Bad operand trapped, then restarted from ERROR.
      do_clear();
      load_word(W0);
      load_word(BAD);
      run_program(1'b0, "bad");
      run_program(1'b0, "bad restart");

      // Full program store, refused extra load, clear, start on empty program.
      do_clear();
      for (int i = 0; i < DEPTH; i++) load_word(rand_word());
      check("full count", 64'(count), 64'(DEPTH));
      load_word(48'hFFFF_FFFF_FFFF);
      check("overfull count", 64'(count), 64'(prog.size()));
      run_program(1'b1, "full");
      do_clear();
      pulse_start();
      check("empty start busy", 64'(busy), 64'(0));
      check("empty start valid", 64'(inst_valid), 64'(0));

      // Randomized programs with random backpressure.
      for (int it = 0; it < 20; it++) begin
         do_clear();
         n = $urandom_range(1, DEPTH);
         for (int j = 0; j < n; j++) load_word(rand_word());
         check("rand count", 64'(count), 64'(prog.size()));
         run_program(1'b1, "rand");
         if ($urandom_range(0, 1) == 1) run_program(1'b1, "rand again");
      end

      // Abort right after the first handshake (in STALL when the interlock is built).
      do_clear();
      load_word(W0);
      load_word(HZ);
      inst_ready = 1'b1;
      push_program(es);
      pulse_start();
      @(posedge clk); #1;
      check("pre-abort valid", 64'(inst_valid), 64'(EXP_GAP == 0));
      check("pre-abort busy", 64'(busy), 64'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort busy", 64'(busy), 64'(0));
      check("abort valid", 64'(inst_valid), 64'(0));
      check("abort pc", 64'(pc), 64'(0));
      check("abort count", 64'(count), 64'(prog.size()));
      sb_q.delete();

      // Asynchronous reset in the middle of a run.
      inst_ready = 1'b0;
      push_program(es);
      pulse_start();
      check("pre-rst valid", 64'(inst_valid), 64'(1));
      #1;
      rst = 1'b1;
      #1;
      check("mid rst valid", 64'(inst_valid), 64'(0));
      check("mid rst count", 64'(count), 64'(0));
      check("mid rst pc", 64'(pc), 64'(0));
      check("mid rst busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      prog.delete();
      sb_q.delete();
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/superalu_issuer.md
# superalu_issuer

Instruction issuer that drives the 48-bit instruction word consumed by the registered super-ALU datapath. It accepts a program of up to `DEPTH` instruction words through a load port and stores them internally. On `start`, it issues the words in order over a valid/ready handshake. An optional interlock holds back any instruction that reads the register the previous instruction wrote, and malformed register operands are trapped before they are issued.

## Interface
- `DEPTH`, 8: program slots, a power of two from 2 to 256.
- `HAZARD_GAP`, 2: stall cycles, 0 to 15, enforced between a write to register d and a later read of d.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `load_valid` in 1: `load_data` is valid this cycle.
- `load_data` in 48: instruction word to append to the program.
- `load_ready` out 1: a load is accepted this cycle.
- `start` in 1: single-cycle pulse; runs the program from slot 0.
- `abort` in 1: single-cycle pulse; stops a run. The program is kept.
- `clear` in 1: single-cycle pulse; empties the program.
- `inst_valid` out 1: `inst` is being offered to the datapath.
- `inst_ready` in 1: the datapath accepts `inst`.
- `inst` out 48: the issued word, with fields op1[47:45], op2[44:42], op3[41:39], rNs/numN at [38]/[37:30], [29]/[28:21], [20]/[19:12], [11]/[10:3], dest[2:0].
- `busy` out 1: the state is RUN or STALL.
- `done` out 1: the program finished.
- `err` out 1: a bad operand was trapped.
- `pc` out clog2(DEPTH) bits: index of the next slot to issue.
- `count` out clog2(DEPTH)+1 bits: number of slots loaded.

## Operation
- States: IDLE, RUN, STALL, DONE, ERROR.
- Reset values: state IDLE, `count`=0, `pc`=0, `inst`=0. `inst_valid`, `busy`, `done` and `err` are 0. `load_ready`=1. The last-dest register is invalid and the gap counter is 0.
- `load_ready` = (state==IDLE) and (`count`<DEPTH).
  - A load (`load_valid` and `load_ready`) writes slot `count` and increments `count`.
  - At `count`==DEPTH, further loads are refused; nothing is overwritten.
- In IDLE, `start` with `count`>0 sets `pc`=0 and enters RUN. `start` with `count`==0 is ignored.
- If a load and `start` occur in the same cycle, the load is performed and `start` is ignored.
- In RUN, slot `pc` is checked before it is presented:
  - Bad operand: any rNs=1 with numN[7:3]≠0. This enters ERROR, sets `err`=1, and the word is never issued.
  - Hazard: any rNs=1 with numN[2:0] equal to the last-dest register, and the gap counter ≠0. This enters STALL.
  - Otherwise `inst_valid`=1 and `inst`=slot `pc`.
- Handshake (`inst_valid` and `inst_ready`):
  - Record dest[2:0] as the last-dest register and load the gap counter with HAZARD_GAP.
  - If `pc`==`count`-1, enter DONE. Otherwise increment `pc`.
- While `inst_valid`=1, `inst` is held stable. Valid is only withdrawn by `abort` or `rst`.
- STALL: the gap counter decrements by 1 each cycle, saturating at 0. When it reaches 0, return to RUN and present the word.
- DONE: `done`=1.
  - `start` restarts from slot 0 and clears `done`.
  - The last-dest register is invalidated on every `start`.
- ERROR: `err` stays 1 and `pc` stays at the offending slot. `start` clears `err` and restarts from slot 0.
- `abort` in RUN or STALL: go to IDLE, `pc`=0, `inst_valid`=0. `abort` in any other state has no effect.
- `clear` from any state: go to IDLE, `count`=0, `pc`=0, and clear `done`/`err`.
- Priority: `rst` > `clear` > `abort` > `start` > handshake.

## Timing
- All outputs are registered, except `load_ready` and `busy`, which are decoded from the state.
- `start` sampled at edge k: `inst_valid`=1 in the cycle after k.
- With no stalls, instructions issue one per cycle back-to-back while `inst_ready`=1.
- Hazard case: handshake at edge m on a word writing d, and the next word reads d.
  - `inst_valid` is 0 for the HAZARD_GAP cycles after m, then 1.
  - With HAZARD_GAP=0 there is no bubble.
- `done` rises in the cycle after the last handshake.
- `err` rises in the cycle after the bad word would have been presented.
- The gap counter runs during any cycle in which the datapath holds `inst_ready` low. A long ready stall can therefore absorb the gap.

## Configuration
- `SUPERALU_ISSUER_HAZARD_EN` defined: the interlock and STALL state are present, as described above.
- Not defined: no hazard check and no STALL state; the gap counter and last-dest register are omitted. The bad-operand trap, `HAZARD_GAP` parameter and all ports remain.

## Test plan
- Reset then load: load 48'h0A0300C02020 and 48'h0D028100301A. Expect `count`=2, then `start`. Expect the two words on consecutive cycles with `inst_ready`=1, then `done`=1 and `pc`=1.
- Hazard: load 48'h0A0300C02020 (dest 0), then 48'h0A4000000001 (reads r0). With HAZARD_GAP=2, expect exactly 2 cycles of `inst_valid`=0 between the handshakes. With the macro undefined, expect 0.
- Backpressure: hold `inst_ready`=0 for 5 cycles. Expect `inst` stable and `inst_valid`=1 throughout, and no `pc` change.
- Bad operand: program {48'h0A0300C02020, 48'h000022000000}. Expect the first word issued, then `err`=1, `pc`=1, and the second word never valid. A later `start` restarts at slot 0.
- Full and clear: 8 loads give `count`=8, `load_ready`=0, and a 9th load is ignored. `clear` gives `count`=0 and `load_ready`=1.
- Abort and reset mid-run: `abort` during STALL gives IDLE, `pc`=0, `count` kept. Asserting `rst` mid-run immediately gives `inst_valid`=0 and `count`=0.
